wm_key_event: RTL and testbench
===============================

# wm_key_event

Button front-end that turns one raw, bouncing push-button input into a debounced level and a set of single-cycle event pulses: short press, long press, and auto-repeat while held. It sits directly upstream of the button-event consumers in the washing-machine panel: the LED selection logic and the buzzer trigger. It runs off the shared 1 ms tick, so panel timing stays consistent across all buttons.

## Interface
Parameters:
- DEBOUNCE_MS, default 20: number of consecutive 1 ms ticks of a stable new value required to accept it.
- LONG_MS, default 1000: held ticks (after the debounced press) at which a long press fires.
- REPEAT_MS, default 200: tick period of repeat pulses after a long press.
- CNT_W, default 12: width of the internal tick counters; must hold max(DEBOUNCE_MS, LONG_MS, REPEAT_MS).

Ports:
- clk  in  1  system clock, 125 MHz.
- reset  in  1  asynchronous, active-high reset.
- clkCnt_1msEnd  in  1  one-clk-wide 1 ms tick from the shared timebase.
- but_in  in  1  raw button, asynchronous to clk, 1 = pressed.
- but_level  out  1  debounced button level.
- but_short  out  1  one-clk pulse: press released before the long threshold.
- but_long  out  1  one-clk pulse: long-press threshold reached.
- but_repeat  out  1  one-clk pulse: auto-repeat while held after a long press.

## Operation
- **Synchronizer:** but_in passes through a 2-FF synchronizer to give sync_in.

- **Debounce (evaluated only on cycles with clkCnt_1msEnd=1):**
  - If sync_in != stable, increment db_cnt. On the tick where db_cnt reaches DEBOUNCE_MS, toggle stable and clear db_cnt.
  - If sync_in == stable, clear db_cnt. Any glitch shorter than DEBOUNCE_MS ticks is therefore ignored.

- **State machine (advances only on ticks):** states are IDLE, PRESS, and HELD.
  - **IDLE:** on a stable rise, go to PRESS and clear hold_cnt.
  - **PRESS:** hold_cnt increments each tick.
    - On a stable fall, pulse but_short and go to IDLE.
    - Otherwise, when hold_cnt reaches LONG_MS, pulse but_long, go to HELD, and clear rep_cnt.
  - **HELD:** rep_cnt increments each tick.
    - When rep_cnt reaches REPEAT_MS, pulse but_repeat and clear rep_cnt.
    - On a stable fall, go to IDLE with no pulse.

- **Simultaneous events:**
  - Release on the same tick as the long threshold: the release wins, so but_short fires and but_long does not.
  - Release on the same tick as a repeat: no repeat pulse is issued.

- **Counters:** hold_cnt and rep_cnt are cleared on every state entry and never wrap while in use.

- **Reset:** reset=1 forces the following, immediately and asynchronously:
  - the synchronizer flops, stable, db_cnt, hold_cnt, and rep_cnt to 0;
  - the state to IDLE;
  - all outputs to 0.

  A button still held when reset releases is re-debounced and treated as a new press.

## Timing
- All outputs are registered. Output reset values: but_level=0, but_short=0, but_long=0, but_repeat=0.
- but_level changes on the clk edge that samples the DEBOUNCE_MS-th qualifying tick. The total latency from a but_in edge is 2 clk plus DEBOUNCE_MS ticks, with up to one tick of jitter.
- Event pulses are high for exactly one clk cycle, on the same edge where the state transition is taken.
- At most one event pulse is asserted per clk cycle.
- If clkCnt_1msEnd is held low, no state, counter, or output changes occur (apart from the synchronizer).

## Structure
- **Shared package wm_pkg:** holds the state encoding constants (IDLE=0, PRESS=1, HELD=2) and the default ms constants, so other panel blocks can reuse them.
- **Sub-module wm_debounce:** contains the synchronizer, db_cnt, and stable, and outputs stable plus rise/fall strobes.
- **Top:** wm_key_event contains the FSM and the hold/repeat counters.

## Test plan
Bench settings: DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, with clkCnt_1msEnd pulsing once every 10 clk.

- **Clean short press:** press 10 ticks, then release.
  - but_level rises on the 4th tick after sync.
  - Exactly one but_short is seen, on the 4th tick after the release.
  - No but_long is seen.
- **Glitches:** pulse but_in for 2 ticks, then for 3 ticks.
  - but_level stays 0.
  - No pulses are seen.
- **Long hold:** hold 32 ticks past the debounced rise, then release.
  - but_long fires at hold tick 20.
  - but_repeat fires at ticks 25 and 30.
  - No but_short is seen on release.
- **Release at the long threshold:** time the debounced fall to land on hold tick 20.
  - Exactly one but_short is seen.
  - No but_long is seen.
- **Reset mid-hold:** assert reset at hold tick 10 while the button stays pressed.
  - All outputs drop to 0 immediately.
  - After reset releases, but_level rises again after 4 ticks.
  - A later release yields one but_short.
- **Tick stalled:** hold clkCnt_1msEnd at 0 for 100 clk while toggling but_in.
  - Outputs and state do not change.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared washing-machine panel definitions: button FSM state encoding and
// default 1 ms-tick timing constants reused by other panel blocks.
package wm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } wm_state_e;

  localparam int WM_DEBOUNCE_MS = 20;
  localparam int WM_LONG_MS     = 1000;
  localparam int WM_REPEAT_MS   = 200;
  localparam int WM_CNT_W       = 12;

endpackage

// File: rtl/wm_debounce.sv
// Two-flop synchronizer plus tick-based debouncer; emits the accepted level and
// combinational rise/fall strobes valid on the tick edge that accepts a change.
module wm_debounce
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_MS = WM_DEBOUNCE_MS,
  parameter int CNT_W       = WM_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync_q1;
  logic             sync_in;
  logic [CNT_W-1:0] db_cnt;
  logic             accept;

  // NOTE: non-blocking assignments make each stage capture the previous stage's old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_in <= sync_q1;
    end
  end

  // The DEBOUNCE_MS-th consecutive differing tick flips the level.
  assign accept = tick && (sync_in != stable) && (db_cnt == DB_LAST);
  assign rise   = accept && !stable;
  assign fall   = accept && stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (tick) begin
      if (sync_in == stable) begin
        db_cnt <= '0;
      end else if (accept) begin
        stable <= ~stable;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wm_key_event.sv
// Button front-end: debounced level plus short / long / auto-repeat event
// pulses, all advancing on the shared 1 ms tick.
module wm_key_event
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_MS = WM_DEBOUNCE_MS,
  parameter int LONG_MS     = WM_LONG_MS,
  parameter int REPEAT_MS   = WM_REPEAT_MS,
  parameter int CNT_W       = WM_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clkCnt_1msEnd,
  input  logic but_in,
  output logic but_level,
  output logic but_short,
  output logic but_long,
  output logic but_repeat
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

  wm_state_e        state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic [CNT_W-1:0] rep_cnt, rep_nx;
  logic             short_nx, long_nx, repeat_nx;
  logic             stable, rise, fall;

  wm_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .tick  (clkCnt_1msEnd),
    .din   (but_in),
    .stable(stable),
    .rise  (rise),
    .fall  (fall)
  );

  // stable is already a flop, so the level needs no extra register stage.
  assign but_level = stable;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nx  = state;
    hold_nx   = hold_cnt;
    rep_nx    = rep_cnt;
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    repeat_nx = 1'b0;
    if (clkCnt_1msEnd) begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = PRESS;
            hold_nx  = '0;
          end
        end
        PRESS: begin
          hold_nx = hold_cnt + 1'b1;
          // A release on the threshold tick wins over the long press.
          if (fall) begin
            short_nx = 1'b1;
            state_nx = IDLE;
            hold_nx  = '0;
            rep_nx   = '0;
          end else if (hold_cnt == LONG_LAST) begin
            long_nx  = 1'b1;
            state_nx = HELD;
            rep_nx   = '0;
          end
        end
        HELD: begin
          rep_nx = rep_cnt + 1'b1;
          if (fall) begin
            state_nx = IDLE;
            hold_nx  = '0;
            rep_nx   = '0;
          end else if (rep_cnt == REP_LAST) begin
            repeat_nx = 1'b1;
            rep_nx    = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          hold_nx  = '0;
          rep_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      rep_cnt    <= '0;
      but_short  <= 1'b0;
      but_long   <= 1'b0;
      but_repeat <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      rep_cnt    <= rep_nx;
      but_short  <= short_nx;
      but_long   <= long_nx;
      but_repeat <= repeat_nx;
    end
  end

endmodule

// File: tb/tb_wm_key_event.sv
// Self-checking bench for wm_key_event: directed scenarios with literal timing
// expectations plus randomized button activity against a behavioural model.
module tb_wm_key_event;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic clk           = 1'b0;
  logic reset         = 1'b1;
  logic clkCnt_1msEnd = 1'b0;
  logic but_in        = 1'b0;
  logic stall         = 1'b0;
  logic cmp_on        = 1'b0;
  logic but_level, but_short, but_long, but_repeat;

  int n_checks = 0;
  int n_fail   = 0;

  wm_key_event #(
    .DEBOUNCE_MS(DB),
    .LONG_MS    (LONG),
    .REPEAT_MS  (REP),
    .CNT_W      (12)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clkCnt_1msEnd(clkCnt_1msEnd),
    .but_in       (but_in),
    .but_level    (but_level),
    .but_short    (but_short),
    .but_long     (but_long),
    .but_repeat   (but_repeat)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // 1 ms tick: one clk wide, every 10 clk, suppressed while stalled.
  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #2;
      div = (div == 9) ? 0 : div + 1;
      clkCnt_1msEnd = (div == 0) && !stall;
    end
  end

  int tick_no = 0;
  always @(posedge clk) if (clkCnt_1msEnd) tick_no++;

  // Behavioural model: level accepted after DB consecutive differing ticks;
  // events derived arithmetically from the number of ticks held since the rise.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0;
  int   m_run = 0, m_held = 0;
  bit   m_pressed = 1'b0, m_rose = 1'b0, m_fell = 1'b0;
  logic exp_short = 1'b0, exp_long = 1'b0, exp_rep = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_held = 0; m_pressed = 0;
      exp_short = 0; exp_long = 0; exp_rep = 0;
    end else begin
      exp_short = 0; exp_long = 0; exp_rep = 0;
      if (clkCnt_1msEnd) begin
        m_rose = 0; m_fell = 0;
        if (m_s2 != m_level) begin
          m_run++;
          if (m_run == DB) begin
            m_level = ~m_level;
            m_run   = 0;
            m_rose  = m_level;
            m_fell  = !m_level;
          end
        end else begin
          m_run = 0;
        end
        if (m_rose) begin
          m_pressed = 1; m_held = 0;
        end else if (m_pressed) begin
          m_held++;
          if (m_fell) begin
            exp_short = (m_held <= LONG);
            m_pressed = 0;
          end else begin
            exp_long = (m_held == LONG);
            exp_rep  = (m_held > LONG) && (((m_held - LONG) % REP) == 0);
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = but_in;
    end
  end

  // Compare process and event recorder (tick index of each observed event).
  int   rise_q[$], short_q[$], long_q[$], rep_q[$];
  logic prev_level = 1'b0;
  int   n_pulse;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("level",  int'(but_level),  int'(m_level));
      check("short",  int'(but_short),  int'(exp_short));
      check("long",   int'(but_long),   int'(exp_long));
      check("repeat", int'(but_repeat), int'(exp_rep));
      n_pulse = int'(but_short) + int'(but_long) + int'(but_repeat);
      check("one_pulse", int'(n_pulse <= 1), 1);
      if (but_level && !prev_level) rise_q.push_back(tick_no);
      if (but_short)  short_q.push_back(tick_no);
      if (but_long)   long_q.push_back(tick_no);
      if (but_repeat) rep_q.push_back(tick_no);
      prev_level = but_level;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!clkCnt_1msEnd);
    end
    #2;
  endtask

  int t0, r0, s0, l0, p0;
  task automatic snap();
    t0 = tick_no;
    r0 = rise_q.size(); s0 = short_q.size(); l0 = long_q.size(); p0 = rep_q.size();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int tr;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level",  int'(but_level),  0);
    check("rst_short",  int'(but_short),  0);
    check("rst_long",   int'(but_long),   0);
    check("rst_repeat", int'(but_repeat), 0);
    @(posedge clk); #2;
    reset  = 1'b0;
    cmp_on = 1'b1;
    wait_ticks(3);

    // Clean short press
    snap();
    but_in = 1; wait_ticks(10); but_in = 0; wait_ticks(8);
    check("s1_rise_tick",  (rise_q.size() > r0) ? rise_q[r0] : -1, t0 + 4);
    check("s1_short_n",    short_q.size() - s0, 1);
    check("s1_short_tick", (short_q.size() > s0) ? short_q[s0] : -1, t0 + 14);
    check("s1_long_n",     long_q.size() - l0, 0);

    // Glitches of 2 and 3 ticks
    snap();
    but_in = 1; wait_ticks(2); but_in = 0; wait_ticks(6);
    but_in = 1; wait_ticks(3); but_in = 0; wait_ticks(8);
    check("s2_rise_n",  rise_q.size() - r0, 0);
    check("s2_level",   int'(but_level), 0);
    check("s2_pulse_n", (short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - p0), 0);

    // Long hold: 32 ticks past the debounced rise
    snap();
    but_in = 1; wait_ticks(36); but_in = 0; wait_ticks(8);
    check("s3_long_n",    long_q.size() - l0, 1);
    check("s3_long_tick", (long_q.size() > l0) ? long_q[l0] : -1, t0 + 4 + 20);
    check("s3_rep_n",     rep_q.size() - p0, 3);
    check("s3_rep0_tick", (rep_q.size() > p0) ? rep_q[p0] : -1, t0 + 4 + 25);
    check("s3_rep1_tick", (rep_q.size() > p0 + 1) ? rep_q[p0 + 1] : -1, t0 + 4 + 30);
    check("s3_short_n",   short_q.size() - s0, 0);

    // Debounced fall landing on hold tick 20
    snap();
    but_in = 1; wait_ticks(20); but_in = 0; wait_ticks(8);
    check("s4_short_n",    short_q.size() - s0, 1);
    check("s4_short_tick", (short_q.size() > s0) ? short_q[s0] : -1, t0 + 24);
    check("s4_long_n",     long_q.size() - l0, 0);

    // Debounced fall landing on the first repeat tick
    snap();
    but_in = 1; wait_ticks(25); but_in = 0; wait_ticks(8);
    check("s5_long_n",  long_q.size() - l0, 1);
    check("s5_rep_n",   rep_q.size() - p0, 0);
    check("s5_short_n", short_q.size() - s0, 0);

    // Reset at hold tick 10 with the button still pressed
    snap();
    but_in = 1; wait_ticks(14);
    check("s6_level_pre", int'(but_level), 1);
    reset = 1'b1;
    #1;
    check("s6_rst_level",  int'(but_level),  0);
    check("s6_rst_short",  int'(but_short),  0);
    check("s6_rst_long",   int'(but_long),   0);
    check("s6_rst_repeat", int'(but_repeat), 0);
    wait_ticks(1);
    reset = 1'b0;
    tr = tick_no;
    wait_ticks(6);
    check("s6_rerise_tick", (rise_q.size() > 0) ? rise_q[rise_q.size() - 1] : -1, tr + 4);
    but_in = 0; wait_ticks(8);
    check("s6_short_n", short_q.size() - s0, 1);

    // Tick stalled for 100 clk while but_in toggles
    snap();
    but_in = 1; wait_ticks(6);
    @(negedge clk) stall = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (i % 7 == 0) but_in = ~but_in;
    end
    but_in = 1;
    repeat (3) @(posedge clk);
    check("s7_stall_level", int'(but_level), 1);
    check("s7_stall_pulses", (short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - p0), 0);
    @(negedge clk) stall = 1'b0;
    wait_ticks(20); but_in = 0; wait_ticks(8);
    check("s7_long_tick", (long_q.size() > l0) ? long_q[l0] : -1, t0 + 4 + 20);

    // Randomized activity, including sub-tick glitches, against the model
    for (int k = 0; k < 40; k++) begin
      but_in = ~but_in;
      wait_ticks($urandom_range(1, 30));
      repeat ($urandom_range(0, 9)) @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) begin
        but_in = ~but_in;
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        but_in = ~but_in;
      end
    end
    but_in = 0;
    wait_ticks(40);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
